regfile_port_master: RTL and testbench



---
 rtl/regfile_port_master.sv | 220 ++++++++++++++++++++++
 tb/tb_regfile_port_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_master.sv
// Initiator side of the register-file port: bulk-loads FIRST_REG..LAST_REG from a
// valid/ready stream and dumps the same range out. Optional readback check: REGFILE_LOAD_VERIFY_EN.
module regfile_port_master #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              dump_start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rf_a1,
    input  logic [DATA_W-1:0] rf_rd1,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              rf_we3
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DUMP   = 3'd2,
`ifdef REGFILE_LOAD_VERIFY_EN
        ST_VERIFY = 3'd3,
`endif
        ST_DONE   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   ptr_r;
    logic                issue_done_r;
    logic [DATA_W-1:0]   m_data_r;
    logic [ADDR_W-1:0]   m_addr_r;
    logic                m_valid_r;
    logic                last_ptr_s;
    logic                m_adv_s;

    assign last_ptr_s = (ptr_r == LAST_A);
    assign m_adv_s    = !m_valid_r || m_ready;

    assign m_data  = m_data_r;
    assign m_addr  = m_addr_r;
    assign m_valid = m_valid_r;
    assign busy    = (state_r != ST_IDLE);
    assign done    = (state_r == ST_DONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and port decode; write strobe is decoded from state so reset kills it at once
    always_comb begin
        state_s = state_r;
        s_ready = 1'b0;
        rf_we3  = 1'b0;
        rf_a1   = '0;
        rf_a3   = ptr_r;
        rf_wd3  = s_data;
        case (state_r)
            ST_IDLE: begin
                if (load_start) begin
                    state_s = ST_LOAD;
                end else if (dump_start) begin
                    state_s = ST_DUMP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                rf_we3  = s_valid;
                if (s_valid && last_ptr_s) begin
`ifdef REGFILE_LOAD_VERIFY_EN
                    state_s = ST_VERIFY;
`else
                    state_s = ST_DONE;
`endif
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DUMP: begin
                rf_a1 = ptr_r;
                if (m_valid_r && m_ready && issue_done_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DUMP;
                end
            end
`ifdef REGFILE_LOAD_VERIFY_EN
            ST_VERIFY: begin
                rf_a1 = ptr_r;
                if (last_ptr_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_VERIFY;
                end
            end
`endif
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pointer and dump output register; ptr rewinds after the last load word for the readback sweep
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r        <= FIRST_A;
            issue_done_r <= 1'b0;
            m_data_r     <= '0;
            m_addr_r     <= '0;
            m_valid_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ptr_r        <= FIRST_A;
                    issue_done_r <= 1'b0;
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        ptr_r <= last_ptr_s ? FIRST_A : (ptr_r + ONE_A);
                    end
                end
                ST_DUMP: begin
                    if (m_adv_s) begin
                        if (!issue_done_r) begin
                            m_data_r  <= rf_rd1;
                            m_addr_r  <= ptr_r;
                            m_valid_r <= 1'b1;
                            if (last_ptr_s) begin
                                issue_done_r <= 1'b1;
                            end else begin
                                ptr_r <= ptr_r + ONE_A;
                            end
                        end else begin
                            m_valid_r <= 1'b0;
                        end
                    end
                end
`ifdef REGFILE_LOAD_VERIFY_EN
                ST_VERIFY: begin
                    ptr_r <= last_ptr_s ? FIRST_A : (ptr_r + ONE_A);
                end
`endif
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

`ifdef REGFILE_LOAD_VERIFY_EN
    logic [DATA_W-1:0] load_xor_r;
    logic [DATA_W-1:0] read_xor_r;
    logic              err_r;

    assign err = err_r;

    // Signature of accepted load words versus readback sweep; err sticks until the next load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_xor_r <= '0;
            read_xor_r <= '0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_start) begin
                        load_xor_r <= '0;
                        read_xor_r <= '0;
                        err_r      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        load_xor_r <= load_xor_r ^ s_data;
                    end
                end
                ST_VERIFY: begin
                    read_xor_r <= read_xor_r ^ rf_rd1;
                    if (last_ptr_s) begin
                        err_r <= (load_xor_r != (read_xor_r ^ rf_rd1));
                    end
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_port_master.sv
// Directed bench for regfile_port_master with a behavioural register file.
module tb_regfile_port_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, dump_start;
    logic [31:0] s_data;
    logic        s_valid, s_ready;
    logic [31:0] m_data;
    logic [4:0]  m_addr;
    logic        m_valid, m_ready;
    logic        busy, done, err;
    logic [4:0]  rf_a1, rf_a3;
    logic [31:0] rf_rd1, rf_wd3;
    logic        rf_we3;

    logic [31:0] rf_mem [0:31];
    int          wr_cnt = 0;
    logic        corrupt = 1'b0;
    int          checks = 0;
    int          failures = 0;

`ifdef REGFILE_LOAD_VERIFY_EN
    localparam int VLAT = 31;
`else
    localparam int VLAT = 0;
`endif

    always #5 clk = ~clk;

    regfile_port_master dut (
        .clk(clk), .rst(rst), .load_start(load_start), .dump_start(dump_start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_addr(m_addr), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .err(err),
        .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3)
    );

    always @(posedge clk) begin
        if (rf_we3) begin
            if (rf_a3 != 5'd0) rf_mem[rf_a3] <= rf_wd3;
            wr_cnt <= wr_cnt + 1;
        end
    end

    assign rf_rd1 = (corrupt && rf_a1 == 5'd9) ? 32'hDEAD_BEEF : rf_mem[rf_a1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic [31:0] base, input bit gaps, input bit both,
                            output int cyc, output int a3_err, output int we_err);
        int i;
        @(negedge clk);
        load_start = 1'b1;
        dump_start = both;
        @(negedge clk);
        load_start = 1'b0;
        dump_start = 1'b0;
        chk("load_entered", {31'd0, s_ready}, 32'd1);
`ifdef REGFILE_LOAD_VERIFY_EN
        chk("err_clear_on_load", {31'd0, err}, 32'd0);
`endif
        i = 0; cyc = 0; a3_err = 0; we_err = 0;
        while (i < 31 && cyc < 200) begin
            s_valid    = gaps ? ((cyc % 2) == 0) : 1'b1;
            s_data     = base + 32'(i + 1);
            dump_start = both && (cyc == 2);
            #1;
            if (rf_a3 != 5'(i + 1)) a3_err++;
            if (rf_we3 != s_valid) we_err++;
            if (s_valid) i++;
            @(negedge clk);
            cyc++;
        end
        s_valid    = 1'b0;
        dump_start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int cyc, a3e, wee, lat, w0, got, stalls, hold_err, ord_err, since_hs;
        bit first;
        rst = 1'b0; load_start = 1'b0; dump_start = 1'b0;
        s_data = 32'd0; s_valid = 1'b0; m_ready = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("rst_mdata", m_data, 32'd0);
        chk("rst_maddr", {27'd0, m_addr}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_we3", {31'd0, rf_we3}, 32'd0);
        chk("rst_sready", {31'd0, s_ready}, 32'd0);

        // asynchronous reset in the middle of a load, after 3 writes
        rst = 1'b1;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        w0 = wr_cnt;
        for (int k = 1; k <= 3; k++) begin
            s_valid = 1'b1;
            s_data  = 32'hA0 + 32'(k);
            @(negedge clk);
        end
        s_data = 32'hA4;
        #1;
        chk("mid_we3_before", {31'd0, rf_we3}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_we3_async", {31'd0, rf_we3}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_mvalid", {31'd0, m_valid}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_wr_cnt", 32'(wr_cnt - w0), 32'd3);
        for (int k = 1; k <= 3; k++) chk("mid_keep", rf_mem[k], 32'hA0 + 32'(k));

        // load with s_valid toggling every other cycle
        w0 = wr_cnt;
        run_load(32'h2000_0000, 1'b1, 1'b0, cyc, a3e, wee);
        wait_done(lat);
        chk("gap_cycles", 32'(cyc), 32'd61);
        chk("gap_ptr_stall", 32'(a3e), 32'd0);
        chk("gap_we_only_hs", 32'(wee), 32'd0);
        chk("gap_wr_cnt", 32'(wr_cnt - w0), 32'd31);
        chk("gap_done_lat", 32'(lat), 32'(VLAT));
        chk("gap_x5", rf_mem[5], 32'h2000_0005);

        // full-throughput load
        w0 = wr_cnt;
        run_load(32'h1000_0000, 1'b0, 1'b0, cyc, a3e, wee);
        chk("full_cycles", 32'(cyc), 32'd31);
        chk("full_wr_cnt", 32'(wr_cnt - w0), 32'd31);
        wait_done(lat);
        chk("full_done_lat", 32'(lat), 32'(VLAT));
        chk("full_busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("full_done_pulse", {31'd0, done}, 32'd0);
        chk("full_busy_after", {31'd0, busy}, 32'd0);
        chk("full_err", {31'd0, err}, 32'd0);
        for (int k = 1; k <= 31; k++) chk("full_data", rf_mem[k], 32'h1000_0000 + 32'(k));

        // dump with 4 cycles of backpressure on x7
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        chk("dump_lat0_valid", {31'd0, m_valid}, 32'd0);
        got = 0; stalls = 0; hold_err = 0; ord_err = 0; since_hs = 99; cyc = 0; first = 1'b1;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            since_hs++;
            if (first) begin
                chk("dump_first_valid", {31'd0, m_valid}, 32'd1);
                chk("dump_first_addr", {27'd0, m_addr}, 32'd1);
                first = 1'b0;
            end
            if (m_valid && m_addr == 5'd7 && stalls < 4) begin
                m_ready = 1'b0;
                stalls++;
                if (m_data != 32'h1000_0007) hold_err++;
            end else begin
                m_ready = 1'b1;
                if (m_valid) begin
                    got++;
                    if (m_addr != 5'(got) || m_data != 32'h1000_0000 + 32'(got)) ord_err++;
                    since_hs = 0;
                end
            end
        end
        m_ready = 1'b1;
        chk("dump_words", 32'(got), 32'd31);
        chk("dump_stalls", 32'(stalls), 32'd4);
        chk("dump_hold", 32'(hold_err), 32'd0);
        chk("dump_order", 32'(ord_err), 32'd0);
        chk("dump_done_after_last", 32'(since_hs), 32'd0);
        chk("dump_cycles", 32'(cyc), 32'd36);
        @(negedge clk);
        chk("dump_done_pulse", {31'd0, done}, 32'd0);
        chk("dump_busy_after", {31'd0, busy}, 32'd0);
        chk("dump_mvalid_after", {31'd0, m_valid}, 32'd0);

`ifdef REGFILE_LOAD_VERIFY_EN
        // readback corrupted on x9 during the verify sweep
        corrupt = 1'b1;
        run_load(32'h4000_0000, 1'b0, 1'b0, cyc, a3e, wee);
        wait_done(lat);
        corrupt = 1'b0;
        chk("vfy_done_lat", 32'(lat), 32'd31);
        @(negedge clk);
        chk("vfy_err_set", {31'd0, err}, 32'd1);
`endif

        // simultaneous starts: load wins; dump_start mid-load is ignored
        run_load(32'h5000_0000, 1'b0, 1'b1, cyc, a3e, wee);
        chk("both_cycles", 32'(cyc), 32'd31);
        chk("both_no_dump_valid", {31'd0, m_valid}, 32'd0);
        wait_done(lat);
        chk("both_done_lat", 32'(lat), 32'(VLAT));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("both_idle_busy", {31'd0, busy}, 32'd0);
        end
        chk("both_err", {31'd0, err}, 32'd0);
        chk("both_x31", rf_mem[31], 32'h5000_001F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
